sseg_scan_n: RTL
================

# sseg_scan_n

Parametrised N-digit seven-segment scan controller, the successor to the fixed 4-digit display path that `procseq` drives on `an`/`sseg`. It time-multiplexes DIGITS hex digits onto one shared active-low segment bus, with per-digit decimal point and blanking. Data loads go through a shadow register and are applied only at frame boundaries, so the display never tears. It sits between the processor/filter datapath and the board's display pins.

## Interface
- `DIGITS`, 4: number of multiplexed digits, 1..8; need not be a power of two.
- `PRESC_W`, 16: prescaler width; each digit is held for 2^PRESC_W clocks (1.31 ms at 50 MHz).
- `clk` in 1: system clock, 50 MHz, T = 20 ns.
- `reset` in 1: synchronous, active-low reset.
- `data` in 4*DIGITS: hex nibbles; `data[3:0]` is digit 0 (rightmost).
- `dp` in DIGITS: decimal point per digit, 1 = lit.
- `blank` in DIGITS: per-digit force-off, 1 = blanked.
- `load` in 1: single-cycle strobe that captures `data`/`dp`/`blank`.
- `an` out DIGITS: digit enables, active-low.
- `sseg` out 8: `sseg[6:0]` = segments g..a, `sseg[7]` = dp; all active-low.
- `busy` out 1: a captured load is waiting for the next frame boundary.

## Operation
- Prescaler `cnt` (PRESC_W bits) counts freely.
  - `tick` = (`cnt` == all ones).
  - On `tick`, the digit index `idx` advances modulo DIGITS, going DIGITS-1 -> 0.
- Frame boundary (`wrap`) = `tick` && `idx` == DIGITS-1.
- Shadow path:
  - `load` copies the inputs into the pending register and sets `busy`.
  - On `wrap` with `busy` set, pending is copied into the display register and `busy` clears.
  - A later `load` before `wrap` overwrites pending; last write wins.
- `load` and `wrap` in the same cycle:
  - The incoming inputs go straight to the display register.
  - `busy` stays 0.
  - Any older pending value is discarded.
- Hex decode is active-low, written {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78.
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Per-cycle output register:
  - `an` has only bit `idx` low.
  - `sseg` = {~dp[idx], decode(nibble[idx])}.
  - If `blank[idx]` is set (or the digit is suppressed, see Configuration), `sseg` = 8'hFF while `an` still strobes.
- Digit enables are strictly one-hot-low, never two digits at once.
- DIGITS=1: `idx` stays 0 and `wrap` = `tick`.

## Timing
- Reset (`reset`=0 at a clk edge) values:
  - `cnt`=0, `idx`=0, `busy`=0.
  - Display and pending registers = 0.
  - `an` = all ones, `sseg` = 8'hFF.
- First cycle after `reset` returns to 1: `an` = ~1 (digit 0) and `sseg` = 8'hC0 ("0").
- Outputs are registered, one clock behind `idx` and the display register.
- `load` to visible change: from 1 cycle (coincident with `wrap`) up to DIGITS*2^PRESC_W + 1 cycles.
- `busy` rises the cycle after `load` and falls the cycle after `wrap`.
- Reset mid-frame or mid-pending:
  - Everything returns to reset values.
  - The pending load is lost.
  - `idx` restarts at 0.
- Inputs other than `load` are sampled only on a `load` cycle.

## Configuration
- `SSEG_LZ_BLANK_EN` defined: leading-zero suppression.
  - Starting at digit DIGITS-1 and moving down, each digit is blanked while its nibble is 0 and its `dp` is 0.
  - Suppression stops at the first nonzero digit or lit dp.
  - Digit 0 is never suppressed.
  - Computed from the display register.
- Undefined: every digit shows its nibble; only `blank` blanks.

## Test plan
Use DIGITS=4, PRESC_W=2 (4 clocks per digit).
- Reset, then release:
  - Cycle 1: `an`=4'b1110, `sseg`=8'hC0.
  - `an` steps 1101, 1011, 0111 every 4 clocks and returns to 1110 after 16.
- `load` `data`=16'h1A8F, `dp`=4'b0100 mid-frame:
  - `busy`=1 until the frame boundary.
  - Next frame: digit0 `sseg`=8'h8E, digit1=8'h80, digit2=8'h08 (dp lit), digit3=8'hF9.
- Two `load`s in one frame (16'h1111, then 16'h2222):
  - Only 2222 appears; digit0 `sseg`=8'hA4.
- `load` in the same cycle as `wrap`:
  - Next frame shows the new data.
  - `busy` never goes 1.
- `blank`=4'b0010 with data 16'h8888:
  - Digit1 slot has `an`=1101 and `sseg`=8'hFF; the other slots show 8'h80.
- With `SSEG_LZ_BLANK_EN` defined and data 16'h0050, `dp`=0:
  - Digits 3 and 2 show 8'hFF, digit1 shows 8'h92, digit0 shows 8'hC0.
  - Apply reset mid-frame: `an`=4'hF and `sseg`=8'hFF on the next cycle.

Source files
------------

// File: rtl/sseg_scan_n.sv
// sseg_scan_n: N-digit multiplexed seven-segment scan controller.
// Shows DIGITS hex digits on a shared active-low segment bus. It has
// per-digit decimal point and blanking. Loads are held in a shadow
// register and applied only at frame boundaries, so the display never
// tears.
// Optional feature: define SSEG_LZ_BLANK_EN to enable leading-zero
// suppression.
module sseg_scan_n #(
   parameter int DIGITS  = 4,
   parameter int PRESC_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   data,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     blank,
   input  logic                  load,
   output logic [DIGITS-1:0]     an,
   output logic [7:0]            sseg,
   output logic                  busy
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0]   LAST    = IDX_W'(DIGITS - 1);
   localparam logic [IDX_W-1:0]   IDX_ONE = IDX_W'(1);
   localparam logic [PRESC_W-1:0] CNT_ONE = PRESC_W'(1);

   logic [PRESC_W-1:0]  cnt;
   logic [IDX_W-1:0]    idx;
   logic                tick;
   logic                wrap;

   logic [4*DIGITS-1:0] pend_data, disp_data;
   logic [DIGITS-1:0]   pend_dp, disp_dp;
   logic [DIGITS-1:0]   pend_blank, disp_blank;

   logic [DIGITS-1:0]   lz;
   logic [DIGITS-1:0]   an_nxt;
   logic [7:0]          sseg_nxt;

   // Active-low hex decode, bits {g,f,e,d,c,b,a}.
   function automatic logic [6:0] seg7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign tick = &cnt;
   assign wrap = tick && (idx == LAST);

   // Prescaler, digit scan and the shadow/display register pair.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt        <= '0;
         idx        <= '0;
         busy       <= 1'b0;
         pend_data  <= '0;
         pend_dp    <= '0;
         pend_blank <= '0;
         disp_data  <= '0;
         disp_dp    <= '0;
         disp_blank <= '0;
      end else begin
         cnt <= cnt + CNT_ONE;
         if (tick)
            idx <= (idx == LAST) ? '0 : idx + IDX_ONE;
         if (load && wrap) begin
            // New data lands directly at the boundary; any older pending value is dropped.
            disp_data  <= data;
            disp_dp    <= dp;
            disp_blank <= blank;
            busy       <= 1'b0;
         end else if (load) begin
            pend_data  <= data;
            pend_dp    <= dp;
            pend_blank <= blank;
            busy       <= 1'b1;
         end else if (wrap && busy) begin
            disp_data  <= pend_data;
            disp_dp    <= pend_dp;
            disp_blank <= pend_blank;
            busy       <= 1'b0;
         end
      end
   end

`ifdef SSEG_LZ_BLANK_EN
   // Leading-zero suppression from the top digit down; digit 0 always shows.
   always_comb begin
      logic run;
      lz  = '0;
      run = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         run   = run && (disp_data[4*i +: 4] == 4'h0) && !disp_dp[i];
         lz[i] = run;
      end
   end
`else
   // No suppression: only the explicit blank mask turns digits off.
   always_comb begin
      lz = '0;
   end
`endif

   // Next digit enable and segment pattern for the current scan index.
   always_comb begin
      an_nxt   = '1;
      sseg_nxt = 8'hFF;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == i[IDX_W-1:0]) begin
            an_nxt[i] = 1'b0;
            if (!(disp_blank[i] || lz[i]))
               sseg_nxt = {~disp_dp[i], seg7(disp_data[4*i +: 4])};
         end
      end
   end

   // Registered outputs, one clock behind idx and the display register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         an   <= '1;
         sseg <= 8'hFF;
      end else begin
         an   <= an_nxt;
         sseg <= sseg_nxt;
      end
   end

endmodule
